// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: imem address/data, execute redirect, and the decode valid/ready
// handshake. master = fetch unit, slave = its environment (imem, execute, decode).
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] o_imem_address;
    logic [DATA_WIDTH-1:0] i_imem_read_data;
    logic                  i_redirect_valid;
    logic [ADDR_WIDTH-1:0] i_redirect_pc;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_instr;
    logic [ADDR_WIDTH-1:0] o_pc;

    modport master (
        output o_imem_address,
        input  i_imem_read_data,
        input  i_redirect_valid,
        input  i_redirect_pc,
        output o_valid,
        input  i_ready,
        output o_instr,
        output o_pc
    );

    modport slave (
        input  o_imem_address,
        output i_imem_read_data,
        output i_redirect_valid,
        output i_redirect_pc,
        input  o_valid,
        output i_ready,
        input  o_instr,
        input  o_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// PC generator + 2-entry {pc, instr} buffer; fetch-to-decode latency 2 cycles.
// Issue is throttled so buffered + in-flight never exceeds 2; redirect flushes.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_fifo_pc    [2];
    logic [DATA_WIDTH-1:0] r_fifo_instr [2];

    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_fetch_addr;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [2:0]            w_occupancy;
    logic                  w_wr_slot;

    assign w_redirect   = bus.i_redirect_valid && !rst;
    assign w_target     = {bus.i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_fetch_addr = w_redirect ? w_target : r_pc;

    assign bus.o_valid        = (r_count != 2'd0) && !w_redirect;
    assign bus.o_pc           = r_fifo_pc[0];
    assign bus.o_instr        = r_fifo_instr[0];
    assign bus.o_imem_address = w_fetch_addr;

    assign w_pop       = bus.o_valid && bus.i_ready;
    assign w_push      = r_inflight && !w_redirect;
    // pop implies count >= 1, so this never underflows
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = !rst && (w_redirect || (w_occupancy < 3'd2));
    assign w_wr_slot   = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_pc   <= '0;
            r_count         <= 2'd0;
            r_fifo_pc[0]    <= '0;
            r_fifo_pc[1]    <= '0;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= w_fetch_addr;
                r_pc          <= w_fetch_addr + ADDR_WIDTH'(4);
            end

            if (w_redirect)
                r_count <= 2'd0;
            else
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            if (w_pop && (r_count == 2'd2)) begin
                r_fifo_pc[0]    <= r_fifo_pc[1];
                r_fifo_instr[0] <= r_fifo_instr[1];
            end
            // slot 0 is only written when the head is free, so this never races the shift
            if (w_push) begin
                r_fifo_pc[w_wr_slot]    <= r_inflight_pc;
                r_fifo_instr[w_wr_slot] <= bus.i_imem_read_data;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run checked
// against a stream model (expected next pc, redirect landing, stall stability).
module tb_instruction_fetch;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem [0:16383];
    logic [31:0] rd_a;
    logic [31:0] rd_b;

    instruction_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_a ();
    instruction_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_b ();

    instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RESET_PC(16'h0000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RESET_PC(16'hFFFC)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rd_a <= mem[bus_a.o_imem_address[15:2]];
        rd_b <= mem[bus_b.o_imem_address[15:2]];
    end
    assign bus_a.i_imem_read_data = rd_a;
    assign bus_b.i_imem_read_data = rd_b;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus_a.o_valid); end
        n_checks++; if (bus_a.o_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", bus_a.o_pc); end
        n_checks++; if (bus_a.o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=00000000", bus_a.o_instr); end
        n_checks++; if (bus_a.o_imem_address !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", bus_a.o_imem_address); end
        n_checks++; if (bus_b.o_imem_address !== 16'hFFFC) begin n_fail++; $display("FAIL reset_addr_b got=%h exp=fffc", bus_b.o_imem_address); end
        n_checks++; if (bus_b.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b got=%0b exp=0", bus_b.o_valid); end
    endtask

    task automatic test_stream();
        logic [15:0] e;
        do_reset();
        bus_a.i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = 16'(4 * k);
            n_checks++; if (bus_a.o_imem_address !== e) begin n_fail++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, bus_a.o_imem_address, e); end
            n_checks++; if (bus_a.o_valid !== (k >= 2)) begin n_fail++; $display("FAIL stream_valid k=%0d got=%0b exp=%0b", k, bus_a.o_valid, k >= 2); end
            if (k >= 2) begin
                e = 16'(4 * (k - 2));
                n_checks++; if (bus_a.o_pc !== e) begin n_fail++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus_a.o_pc, e); end
                n_checks++; if (bus_a.o_instr !== mem[e[15:2]]) begin n_fail++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus_a.o_instr, mem[e[15:2]]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [15:0] e;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            bus_a.i_ready = (k < 2) || (k >= 7);
            @(negedge clk);
            if (k >= 2 && k < 7) begin
                n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid k=%0d got=%0b exp=1", k, bus_a.o_valid); end
                n_checks++; if (bus_a.o_pc !== 16'h0) begin n_fail++; $display("FAIL stall_pc k=%0d got=%h exp=0000", k, bus_a.o_pc); end
                n_checks++; if (bus_a.o_instr !== 32'h12345678) begin n_fail++; $display("FAIL stall_instr k=%0d got=%h exp=12345678", k, bus_a.o_instr); end
                n_checks++; if (bus_a.o_imem_address !== 16'h8) begin n_fail++; $display("FAIL stall_addr k=%0d got=%h exp=0008", k, bus_a.o_imem_address); end
            end else if (k >= 7) begin
                e = 16'(4 * (k - 7));
                n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid k=%0d got=%0b exp=1", k, bus_a.o_valid); end
                n_checks++; if (bus_a.o_pc !== e) begin n_fail++; $display("FAIL drain_pc k=%0d got=%h exp=%h", k, bus_a.o_pc, e); end
                n_checks++; if (bus_a.o_instr !== mem[e[15:2]]) begin n_fail++; $display("FAIL drain_instr k=%0d got=%h exp=%h", k, bus_a.o_instr, mem[e[15:2]]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus_a.i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus_a.i_redirect_valid = (k == 2);
            bus_a.i_redirect_pc    = 16'h000A;
            @(negedge clk);
            if (k == 2) begin
                n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_r got=%0b exp=0", bus_a.o_valid); end
                n_checks++; if (bus_a.o_imem_address !== 16'h0008) begin n_fail++; $display("FAIL redir_addr got=%h exp=0008", bus_a.o_imem_address); end
            end
            if (k == 3) begin
                n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_r1 got=%0b exp=0", bus_a.o_valid); end
            end
            if (k == 4 || k == 5) begin
                n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL redir_land_valid k=%0d got=%0b exp=1", k, bus_a.o_valid); end
                n_checks++; if (bus_a.o_pc !== ((k == 4) ? 16'h0008 : 16'h000C)) begin n_fail++; $display("FAIL redir_land_pc k=%0d got=%h", k, bus_a.o_pc); end
                n_checks++; if (bus_a.o_instr !== ((k == 4) ? 32'hbeefcafe : 32'h00000013)) begin n_fail++; $display("FAIL redir_land_instr k=%0d got=%h", k, bus_a.o_instr); end
            end
            @(posedge clk); #1;
        end
        bus_a.i_redirect_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_a.i_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus_a.i_redirect_valid = (k == 4) || (k == 5);
            bus_a.i_redirect_pc    = (k == 4) ? 16'h0004 : 16'h0000;
            @(negedge clk);
            if (k >= 4 && k <= 6) begin
                n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid k=%0d got=%0b exp=0", k, bus_a.o_valid); end
            end
            if (k == 4 || k == 5) begin
                n_checks++; if (bus_a.o_imem_address !== ((k == 4) ? 16'h4 : 16'h0)) begin n_fail++; $display("FAIL b2b_addr k=%0d got=%h", k, bus_a.o_imem_address); end
            end
            if (k >= 7) begin
                n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_land_valid k=%0d got=%0b exp=1", k, bus_a.o_valid); end
                n_checks++; if (bus_a.o_pc !== 16'(4 * (k - 7))) begin n_fail++; $display("FAIL b2b_land_pc k=%0d got=%h exp=%h", k, bus_a.o_pc, 16'(4 * (k - 7))); end
                n_checks++; if (bus_a.o_instr !== ((k == 7) ? 32'h12345678 : 32'hdeadbeef)) begin n_fail++; $display("FAIL b2b_land_instr k=%0d got=%h", k, bus_a.o_instr); end
            end
            @(posedge clk); #1;
        end
        bus_a.i_redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        do_reset();
        bus_a.i_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prevalid got=%0b exp=1", bus_a.o_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got=%0b exp=0", bus_a.o_valid); end
        n_checks++; if (bus_a.o_imem_address !== 16'h0) begin n_fail++; $display("FAIL mid_async_addr got=%h exp=0000", bus_a.o_imem_address); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (bus_a.o_imem_address !== 16'(4 * k)) begin n_fail++; $display("FAIL mid_addr k=%0d got=%h exp=%h", k, bus_a.o_imem_address, 16'(4 * k)); end
            n_checks++; if (bus_a.o_valid !== (k >= 2)) begin n_fail++; $display("FAIL mid_valid k=%0d got=%0b", k, bus_a.o_valid); end
            if (k >= 2) begin
                e = 16'(4 * (k - 2));
                n_checks++; if (bus_a.o_pc !== e) begin n_fail++; $display("FAIL mid_pc k=%0d got=%h exp=%h", k, bus_a.o_pc, e); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = 16'hFFFC + 16'(4 * k);
            n_checks++; if (bus_b.o_imem_address !== e) begin n_fail++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, bus_b.o_imem_address, e); end
            n_checks++; if (bus_b.o_valid !== (k >= 2)) begin n_fail++; $display("FAIL wrap_valid k=%0d got=%0b", k, bus_b.o_valid); end
            if (k >= 2) begin
                e = 16'hFFFC + 16'(4 * (k - 2));
                n_checks++; if (bus_b.o_pc !== e) begin n_fail++; $display("FAIL wrap_pc k=%0d got=%h exp=%h", k, bus_b.o_pc, e); end
                n_checks++; if (bus_b.o_instr !== mem[e[15:2]]) begin n_fail++; $display("FAIL wrap_instr k=%0d got=%h exp=%h", k, bus_b.o_instr, mem[e[15:2]]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, tgt, land_pc, prev_pc;
        logic [31:0] prev_instr;
        logic        redir, stall_prev;
        int          land_at, pops;
        do_reset();
        exp_pc     = 16'h0;
        stall_prev = 1'b0;
        land_at    = -1;
        land_pc    = 16'h0;
        prev_pc    = 16'h0;
        prev_instr = 32'h0;
        pops       = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redir = ($urandom_range(0, 15) == 0);
            tgt   = 16'($urandom_range(0, 65535));
            bus_a.i_ready          = ($urandom_range(0, 3) != 0);
            bus_a.i_redirect_valid = redir;
            bus_a.i_redirect_pc    = tgt;
            @(negedge clk);
            if (redir) begin
                n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_valid cyc=%0d got=%0b exp=0", cyc, bus_a.o_valid); end
                n_checks++; if (bus_a.o_imem_address !== {tgt[15:2], 2'b00}) begin n_fail++; $display("FAIL rnd_redir_addr cyc=%0d got=%h exp=%h", cyc, bus_a.o_imem_address, {tgt[15:2], 2'b00}); end
            end
            if (stall_prev && !redir) begin
                n_checks++;
                if (bus_a.o_valid !== 1'b1 || bus_a.o_pc !== prev_pc || bus_a.o_instr !== prev_instr) begin
                    n_fail++; $display("FAIL rnd_hold cyc=%0d got=%0b/%h/%h exp=1/%h/%h", cyc, bus_a.o_valid, bus_a.o_pc, bus_a.o_instr, prev_pc, prev_instr);
                end
            end
            if (cyc == land_at && !redir) begin
                n_checks++;
                if (bus_a.o_valid !== 1'b1 || bus_a.o_pc !== land_pc) begin
                    n_fail++; $display("FAIL rnd_land cyc=%0d got=%0b/%h exp=1/%h", cyc, bus_a.o_valid, bus_a.o_pc, land_pc);
                end
            end
            if (bus_a.o_valid && bus_a.i_ready) begin
                pops++;
                n_checks++;
                if (bus_a.o_pc !== exp_pc || bus_a.o_instr !== mem[exp_pc[15:2]]) begin
                    n_fail++; $display("FAIL rnd_deliver cyc=%0d got=%h/%h exp=%h/%h", cyc, bus_a.o_pc, bus_a.o_instr, exp_pc, mem[exp_pc[15:2]]);
                end
                exp_pc = exp_pc + 16'd4;
            end
            if (redir) begin
                exp_pc  = {tgt[15:2], 2'b00};
                land_pc = {tgt[15:2], 2'b00};
                land_at = cyc + 2;
            end
            stall_prev = bus_a.o_valid && !bus_a.i_ready;
            prev_pc    = bus_a.o_pc;
            prev_instr = bus_a.o_instr;
            @(posedge clk); #1;
        end
        bus_a.i_redirect_valid = 1'b0;
        n_checks++; if (pops < 1000) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=1000", pops); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h12345678;
        mem[1] = 32'hdeadbeef;
        mem[2] = 32'hbeefcafe;
        mem[3] = 32'h00000013;
        bus_a.i_ready          = 1'b1;
        bus_a.i_redirect_valid = 1'b0;
        bus_a.i_redirect_pc    = 16'h0;
        bus_b.i_ready          = 1'b1;
        bus_b.i_redirect_valid = 1'b0;
        bus_b.i_redirect_pc    = 16'h0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
